// File: rtl/mc_pkg.sv
// Shared definitions for the MC counter read-out path: frame FSM states and
// default geometry (word width, channel count, header magic, frame length).
// Ports: none (package only).
package mc_pkg;

   localparam int unsigned MC_W         = 16;
   localparam int unsigned MC_N_CH      = 32;
   localparam logic [7:0]  MC_MAGIC     = 8'hA5;
   // header + catch + fb + channels + checksum
   localparam int unsigned MC_FRAME_LEN = MC_N_CH + 4;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      CAT,
      FB,
      CH,
      CSUM,
      CLR
   } mc_state_t;

endpackage

// File: rtl/mc_counter_reader.sv
// Purpose: snapshot catch/fb/channel counters on request and stream them as a
//   framed W-bit word sequence (header, catch, fb, N_CH channels, checksum),
//   optionally pulsing a clear to the counter bank after the frame completes.
// Latency: first word valid 1 cycle after the request edge; 1 word/cycle after.
// Backpressure: each word is held stable on io_txData while io_txValid=1 and
//   io_txReady=0; requests arriving while busy are dropped and flagged.
// Ports: io_clk/io_rst_n (sync, active low); live counters in; io_req and
//   io_clrOnRead control; io_tx* stream out; io_busy/io_overrun/io_clr/io_seq.
module mc_counter_reader
   import mc_pkg::*;
#(
   parameter int unsigned N_CH  = MC_N_CH,
   parameter int unsigned W     = MC_W,
   parameter logic [7:0]  MAGIC = MC_MAGIC
) (
   input  logic            io_clk,
   input  logic            io_rst_n,
   input  logic [W-1:0]    io_catchCounter,
   input  logic [W-1:0]    io_fbCounter,
   input  logic [W*N_CH-1:0] io_outCounter,
   input  logic            io_req,
   input  logic            io_clrOnRead,
   output logic [W-1:0]    io_txData,
   output logic            io_txValid,
   input  logic            io_txReady,
   output logic            io_txLast,
   output logic            io_busy,
   output logic            io_overrun,
   output logic            io_clr,
   output logic [7:0]      io_seq
);

   localparam int unsigned      IDX_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

   mc_state_t        state_q;
   logic [IDX_W-1:0] idx_q;
   logic [7:0]       seq_q;
   logic [W-1:0]     sum_q;
   logic [W-1:0]     cat_q;
   logic [W-1:0]     fb_q;
   logic [W-1:0]     ch_q [N_CH];
   logic [W-1:0]     data_q;
   logic             valid_q;
   logic             last_q;
   logic             clr_q;
   logic             overrun_q;

   logic             accept;
   logic [7:0]       seq_d;
   logic [W-1:0]     hdr_word;
   logic [IDX_W-1:0] idx_d;

   assign accept   = valid_q & io_txReady;
   assign seq_d    = seq_q + 8'd1;
   assign hdr_word = W'({MAGIC, seq_d});
   assign idx_d    = idx_q + 1'b1;

   // sum_q always holds the sum of every word issued so far in this frame,
   // including the one currently presented, so the checksum word is simply
   // sum_q at the moment the last channel word is accepted.
   always_ff @(posedge io_clk) begin
      if (!io_rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         seq_q     <= '0;
         sum_q     <= '0;
         cat_q     <= '0;
         fb_q      <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         clr_q     <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < int'(N_CH); i++) begin
            ch_q[i] <= '0;
         end
      end else begin
         overrun_q <= io_req && (state_q != IDLE);
         clr_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (io_req) begin
                  cat_q <= io_catchCounter;
                  fb_q  <= io_fbCounter;
                  for (int i = 0; i < int'(N_CH); i++) begin
                     ch_q[i] <= io_outCounter[i*W +: W];
                  end
                  seq_q   <= seq_d;
                  sum_q   <= hdr_word;
                  data_q  <= hdr_word;
                  valid_q <= 1'b1;
                  state_q <= HDR;
               end
            end
            HDR: begin
               if (accept) begin
                  data_q  <= cat_q;
                  sum_q   <= sum_q + cat_q;
                  state_q <= CAT;
               end
            end
            CAT: begin
               if (accept) begin
                  data_q  <= fb_q;
                  sum_q   <= sum_q + fb_q;
                  state_q <= FB;
               end
            end
            FB: begin
               if (accept) begin
                  data_q  <= ch_q[0];
                  sum_q   <= sum_q + ch_q[0];
                  idx_q   <= '0;
                  state_q <= CH;
               end
            end
            CH: begin
               if (accept) begin
                  if (idx_q == LAST_IDX) begin
                     data_q  <= sum_q;
                     last_q  <= 1'b1;
                     state_q <= CSUM;
                  end else begin
                     data_q <= ch_q[idx_d];
                     sum_q  <= sum_q + ch_q[idx_d];
                     idx_q  <= idx_d;
                  end
               end
            end
            CSUM: begin
               if (accept) begin
                  data_q  <= '0;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  if (io_clrOnRead) begin
                     clr_q   <= 1'b1;
                     state_q <= CLR;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            CLR: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign io_txData  = data_q;
   assign io_txValid = valid_q;
   assign io_txLast  = last_q;
   assign io_busy    = (state_q != IDLE);
   assign io_overrun = overrun_q;
   assign io_clr     = clr_q;
   assign io_seq     = seq_q;

endmodule

// File: tb/tb_mc_counter_reader.sv
module tb_mc_counter_reader;
   import mc_pkg::*;

   localparam int W = MC_W;
   localparam int N = MC_N_CH;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [W-1:0]     io_catchCounter = '0;
   logic [W-1:0]     io_fbCounter = '0;
   logic [W*N-1:0]   io_outCounter = '0;
   logic             io_req = 1'b0;
   logic             io_clrOnRead = 1'b0;
   logic [W-1:0]     io_txData;
   logic             io_txValid;
   logic             io_txReady = 1'b0;
   logic             io_txLast;
   logic             io_busy;
   logic             io_overrun;
   logic             io_clr;
   logic [7:0]       io_seq;

   mc_counter_reader dut (
      .io_clk          (clk),
      .io_rst_n        (rst_n),
      .io_catchCounter (io_catchCounter),
      .io_fbCounter    (io_fbCounter),
      .io_outCounter   (io_outCounter),
      .io_req          (io_req),
      .io_clrOnRead    (io_clrOnRead),
      .io_txData       (io_txData),
      .io_txValid      (io_txValid),
      .io_txReady      (io_txReady),
      .io_txLast       (io_txLast),
      .io_busy         (io_busy),
      .io_overrun      (io_overrun),
      .io_clr          (io_clr),
      .io_seq          (io_seq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] dat;
      logic        last;
      logic        clr;
      logic        hdr;
      logic [7:0]  seq;
   } exp_t;

   exp_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         pops = 0;
   logic [7:0] seq_m = 8'd0;
   int         rdy_mode = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Downstream readiness: always, one cycle in three, or random.
   initial begin : ready_drv
      int cyc;
      cyc = 0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         case (rdy_mode)
            0:       io_txReady = 1'b1;
            1:       io_txReady = (cyc % 3 == 0);
            default: io_txReady = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops the expected word on each handshake, checks stall stability
   // and the clear pulse that must follow the final word.
   initial begin : monitor
      logic        stalled;
      logic [15:0] held;
      logic        clr_chk;
      logic        clr_exp;
      exp_t        e;
      stalled = 1'b0;
      held = '0;
      clr_chk = 1'b0;
      clr_exp = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled = 1'b0;
            clr_chk = 1'b0;
            continue;
         end
         if (clr_chk) chk("clr_after_last", 32'(io_clr), 32'(clr_exp));
         else if (io_clr) chk("clr_unexpected", 32'(io_clr), 32'd0);
         clr_chk = 1'b0;
         if (stalled) begin
            chk("stall_valid", 32'(io_txValid), 32'd1);
            chk("stall_data", 32'(io_txData), 32'(held));
         end
         stalled = 1'b0;
         if (io_txValid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", 32'(io_txValid), 32'd0);
            end else if (io_txReady) begin
               e = exp_q.pop_front();
               pops++;
               chk("word", 32'(io_txData), 32'(e.dat));
               chk("last", 32'(io_txLast), 32'(e.last));
               if (e.hdr) chk("seq", 32'(io_seq), 32'(e.seq));
               if (e.last) begin
                  clr_chk = 1'b1;
                  clr_exp = e.clr;
               end
            end else begin
               stalled = 1'b1;
               held = io_txData;
            end
         end
      end
   end

   task automatic set_pattern();
      io_catchCounter = 16'd3;
      io_fbCounter = 16'd7;
      for (int i = 0; i < N; i++) io_outCounter[i*W +: W] = 16'(i + 1);
   endtask

   task automatic set_all(input logic [15:0] v);
      io_catchCounter = v;
      io_fbCounter = v;
      for (int i = 0; i < N; i++) io_outCounter[i*W +: W] = v;
   endtask

   task automatic set_random();
      io_catchCounter = 16'($urandom);
      io_fbCounter = 16'($urandom);
      for (int i = 0; i < N; i++) io_outCounter[i*W +: W] = 16'($urandom);
   endtask

   // Waits for IDLE, builds the whole expected frame from the current live
   // counters, pulses io_req for one edge, then optionally disturbs counters.
   task automatic start_frame(input logic clr_on_read, input int after_mode);
      int          t;
      logic [15:0] w[$];
      logic [15:0] s;
      t = 0;
      while (io_busy && t < 400) begin
         @(posedge clk); #1;
         t++;
      end
      if (io_busy) begin
         chk("idle_timeout", 32'(io_busy), 32'd0);
         return;
      end
      seq_m = seq_m + 8'd1;
      w.push_back({MC_MAGIC, seq_m});
      w.push_back(io_catchCounter);
      w.push_back(io_fbCounter);
      for (int i = 0; i < N; i++) w.push_back(io_outCounter[i*W +: W]);
      s = '0;
      foreach (w[k]) s = s + w[k];
      foreach (w[k]) exp_q.push_back('{dat: w[k], last: 1'b0, clr: 1'b0, hdr: (k == 0), seq: seq_m});
      exp_q.push_back('{dat: s, last: 1'b1, clr: clr_on_read, hdr: 1'b0, seq: seq_m});
      io_clrOnRead = clr_on_read;
      io_req = 1'b1;
      @(posedge clk); #1;
      io_req = 1'b0;
      if (after_mode == 1) set_all(16'hFFFF);
      else if (after_mode == 2) set_random();
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || io_busy) && t < 600) begin
         @(posedge clk); #1;
         t++;
      end
      if (exp_q.size() != 0 || io_busy) chk("frame_timeout", 32'(exp_q.size()), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_pops(input int target);
      int t;
      t = 0;
      while (pops < target && t < 600) begin
         @(posedge clk); #1;
         t++;
      end
      if (pops < target) chk("pop_timeout", 32'(pops), 32'(target));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", checks);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int base;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(io_txValid), 32'd0);
      chk("rst_data", 32'(io_txData), 32'd0);
      chk("rst_last", 32'(io_txLast), 32'd0);
      chk("rst_busy", 32'(io_busy), 32'd0);
      chk("rst_overrun", 32'(io_overrun), 32'd0);
      chk("rst_clr", 32'(io_clr), 32'd0);
      chk("rst_seq", 32'(io_seq), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full-rate frame with the reference counter pattern.
      rdy_mode = 0;
      set_pattern();
      @(posedge clk); #1;
      base = pops;
      start_frame(1'b0, 0);
      repeat (MC_FRAME_LEN) begin
         @(posedge clk); #1;
      end
      chk("b2b_words", 32'(pops - base), 32'(MC_FRAME_LEN));
      chk("b2b_idle", 32'(io_busy), 32'd0);
      wait_done();

      // Throttled link, same counters.
      rdy_mode = 1;
      start_frame(1'b0, 0);
      wait_done();

      // Live counters jump to FFFF right after the request.
      rdy_mode = 2;
      start_frame(1'b0, 1);
      wait_done();

      // Request mid-frame is flagged and dropped.
      set_random();
      base = pops;
      start_frame(1'b0, 2);
      wait_pops(base + 10);
      io_req = 1'b1;
      @(posedge clk); #1;
      io_req = 1'b0;
      chk("overrun_pulse", 32'(io_overrun), 32'd1);
      @(posedge clk); #1;
      chk("overrun_end", 32'(io_overrun), 32'd0);
      wait_done();
      repeat (5) begin
         @(posedge clk); #1;
      end
      chk("dropped_req_idle", 32'(io_busy), 32'd0);
      start_frame(1'b0, 2);
      wait_done();

      // Clear on read, then without.
      rdy_mode = 0;
      start_frame(1'b1, 2);
      wait_done();
      start_frame(1'b0, 2);
      wait_done();

      // Reset in the middle of a clear-on-read frame.
      rdy_mode = 2;
      base = pops;
      start_frame(1'b1, 2);
      wait_pops(base + 20);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_valid", 32'(io_txValid), 32'd0);
      chk("midrst_busy", 32'(io_busy), 32'd0);
      chk("midrst_seq", 32'(io_seq), 32'd0);
      chk("midrst_last", 32'(io_txLast), 32'd0);
      exp_q.delete();
      seq_m = 8'd0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("midrst_no_clr", 32'(io_clr), 32'd0);
      end
      start_frame(1'b0, 2);
      wait_done();

      // Random mix.
      for (int f = 0; f < 4; f++) begin
         rdy_mode = $urandom_range(0, 2);
         set_random();
         start_frame(1'($urandom_range(0, 1)), 2);
         wait_done();
      end

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
